vga_sync_receiver: RTL and testbench
====================================

Name: vga_sync_receiver

Overview:
- Sink end of the team's VGA timing interface.
- Consumes the hsync/vsync/blank_n stream that the VGA driver produces and recovers visible-pixel coordinates from it.
- Measures line and frame periods, acquires and tracks lock, and counts timing errors.
- Used as an on-chip monitor alongside the display path, and as the checker in driver benches.

Parameters:
- H_TOTAL, 800, pixel strobes per line
- V_TOTAL, 525, lines per frame
- HS_ACTIVE, 0, asserted level of vgaHs
- VS_ACTIVE, 0, asserted level of vgaVs

Ports:
- CLOCK_50  in  1  system clock; single clock domain
- resetn  in  1  asynchronous active-low reset
- pixEn  in  1  one-cycle pixel strobe; all sync/blank inputs are sampled only when high
- vgaHs  in  1  horizontal sync
- vgaVs  in  1  vertical sync
- vgaBlankN  in  1  high on visible pixels
- xOrd  out  10  visible column of the last valid pixel
- yOrd  out  10  visible row of the last valid pixel
- pixValid  out  1  one-cycle pulse per visible pixel while locked
- locked  out  1  timing lock indicator
- lineErr  out  1  one-cycle error pulse
- frameDone  out  1  one-cycle pulse at each frame boundary while locked
- hTotalMeas  out  10  last measured line length
- vTotalMeas  out  10  last measured frame length, in lines
- errCount  out  8  saturating error counter

Behaviour:
- Reset: all outputs and counters go to 0 and the state goes to SEARCH. Previous-sample registers for hs/vs reset to the inactive level, so a sync already asserted at its first sample counts as a leading edge. Reset asserted mid-frame clears everything immediately; lock must then be fully reacquired.
- Register update: every register updates only on CLOCK_50 edges where pixEn=1. Pulse outputs are high for exactly the one cycle following such an edge.
- Edge detection: a leading edge (hsEdge/vsEdge) is an inactive-to-active transition between successive pixEn samples.
- hCnt (10-bit, saturates at 1023):
  - On hsEdge: hTotalMeas <= hCnt+1, then hCnt <= 0.
  - Otherwise: hCnt increments.
- vCnt (10-bit) increments on each hsEdge. On vsEdge: vTotalMeas <= vCnt + (hsEdge ? 1 : 0), then vCnt <= 0. When both edges occur on the same sample, vsEdge has priority, and the hsEdge is counted into the frame that is ending.
- Coordinates:
  - xRun clears on hsEdge.
  - On a sample with vgaBlankN=1: xOrd <= xRun, yOrd <= yRun, xRun++, and pixValid pulses if locked=1.
  - yRun increments on hsEdge if the line just ended had at least one visible pixel. yRun clears on vsEdge.
  - In SEARCH/ALIGN, xOrd/yOrd still update but pixValid stays 0.
- State machine:
  - SEARCH: vsEdge moves to ALIGN.
  - ALIGN:
    - An hsEdge with hCnt+1 != H_TOTAL returns to SEARCH.
    - A vsEdge with a measured vTotal of V_TOTAL moves to LOCKED; other vTotal values return to SEARCH.
    - No lineErr or errCount activity occurs in ALIGN.
  - LOCKED (locked=1):
    - hsEdge with a bad length: lineErr pulses, errCount increments (saturating at 255), state stays LOCKED.
    - vsEdge with a good vTotal: frameDone pulses.
    - vsEdge with a bad vTotal: lineErr pulses, errCount increments, state moves to SEARCH.
    - hCnt reaching 1023 (hsync lost): lineErr pulses, errCount increments, state moves to SEARCH.
- locked is registered: it rises on the pixEn edge that takes the ALIGN-to-LOCKED transition and falls on the edge that leaves LOCKED. frameDone and pixValid are not asserted on the exit edge.
- errCount is cleared only by reset.
- Latency: one CLOCK_50 cycle from the sampled pixEn edge to all outputs.

Test Plan:
1. Nominal 640x480 stream from the driver, pixEn every second cycle:
   - locked rises at the 2nd vsync leading edge.
   - hTotalMeas=800, vTotalMeas=525.
   - 307200 pixValid pulses per frame; the last pulse shows xOrd=639, yOrd=479; frameDone pulses once per frame.
2. While locked, stretch one line to 801 pixels:
   - One lineErr pulse, errCount=1, hTotalMeas=801, locked stays 1.
   - The next line measures 800.
3. While locked, shorten one frame to 524 lines:
   - At vsEdge: lineErr pulses, errCount increments, locked=0, vTotalMeas=524.
   - locked returns after two further good vsync edges.
4. Hold vgaHs inactive while locked:
   - locked falls on the 1023rd strobe after the last hsEdge.
   - lineErr pulses once; no pixValid afterwards.
5. Assert resetn low mid-frame, then release:
   - All outputs are 0 immediately.
   - Relock needs exactly two vsync edges; xOrd/yOrd restart from 0,0.
6. Drive 300 lines of length 799 while locked:
   - errCount saturates at 255; lineErr still pulses per bad line; locked stays 1.

Source files
------------

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: sink for the VGA timing stream (hsync/vsync/blank_n).
// Recovers visible-pixel coordinates and measures line and frame periods.
// Acquires lock over two frames and counts timing errors.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   SEARCH | waiting for a vsync leading edge to start a measurement
//   ALIGN  | one frame under observation; every line must be H_TOTAL
//   LOCKED | timing tracked; bad lines/frames are reported as lineErr
module vga_sync_receiver #(
  parameter int unsigned H_TOTAL   = 800,
  parameter int unsigned V_TOTAL   = 525,
  parameter bit          HS_ACTIVE = 1'b0,
  parameter bit          VS_ACTIVE = 1'b0
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       pixEn,
  input  logic       vgaHs,
  input  logic       vgaVs,
  input  logic       vgaBlankN,
  output logic [9:0] xOrd,
  output logic [9:0] yOrd,
  output logic       pixValid,
  output logic       locked,
  output logic       lineErr,
  output logic       frameDone,
  output logic [9:0] hTotalMeas,
  output logic [9:0] vTotalMeas,
  output logic [7:0] errCount
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam logic [10:0] H_TOT_L = 11'(H_TOTAL);
  localparam logic [10:0] V_TOT_L = 11'(V_TOTAL);
  localparam logic [9:0]  CNT_MAX = 10'h3FF;

  state_e     state_q, state_d;
  logic       hs_prev_q, hs_prev_d;
  logic       vs_prev_q, vs_prev_d;
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic [9:0] h_total_q, h_total_d;
  logic [9:0] v_total_q, v_total_d;
  logic [9:0] x_run_q, x_run_d;
  logic [9:0] y_run_q, y_run_d;
  logic       line_vis_q, line_vis_d;
  logic [9:0] x_ord_q, x_ord_d;
  logic [9:0] y_ord_q, y_ord_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       pix_valid_q, pix_valid_d;
  logic       line_err_q, line_err_d;
  logic       frame_done_q, frame_done_d;

  logic        hs_edge, vs_edge, h_lost, h_bad, v_bad;
  logic [10:0] h_len, v_len;
  logic [9:0]  x_base, y_base;

  // Leading-edge detection and period measurement, qualified by the pixel strobe.
  always_comb begin
    hs_edge = pixEn && (vgaHs == HS_ACTIVE) && (hs_prev_q != HS_ACTIVE);
    vs_edge = pixEn && (vgaVs == VS_ACTIVE) && (vs_prev_q != VS_ACTIVE);
    h_len   = {1'b0, hcnt_q} + 11'd1;
    // An hsync on the vsync sample still belongs to the frame that is ending.
    v_len   = {1'b0, vcnt_q} + {10'd0, hs_edge};
    h_bad   = (h_len != H_TOT_L);
    v_bad   = (v_len != V_TOT_L);
    // Fires once, on the strobe where the line counter reaches saturation.
    h_lost  = pixEn && !hs_edge && (hcnt_q == CNT_MAX - 10'd1);
    x_base  = hs_edge ? 10'd0 : x_run_q;
    if (vs_edge)
      y_base = 10'd0;
    else if (hs_edge && line_vis_q)
      y_base = y_run_q + 10'd1;
    else
      y_base = y_run_q;
  end

  // Datapath next-state: counters, measurements and coordinates.
  always_comb begin
    hs_prev_d  = hs_prev_q;
    vs_prev_d  = vs_prev_q;
    hcnt_d     = hcnt_q;
    vcnt_d     = vcnt_q;
    h_total_d  = h_total_q;
    v_total_d  = v_total_q;
    x_run_d    = x_run_q;
    y_run_d    = y_run_q;
    line_vis_d = line_vis_q;
    x_ord_d    = x_ord_q;
    y_ord_d    = y_ord_q;
    if (pixEn) begin
      hs_prev_d = vgaHs;
      vs_prev_d = vgaVs;
      if (hs_edge) begin
        h_total_d = h_len[9:0];
        hcnt_d    = 10'd0;
      end else if (hcnt_q != CNT_MAX) begin
        hcnt_d = hcnt_q + 10'd1;
      end
      if (vs_edge) begin
        v_total_d = v_len[9:0];
        vcnt_d    = 10'd0;
      end else if (hs_edge && vcnt_q != CNT_MAX) begin
        vcnt_d = vcnt_q + 10'd1;
      end
      x_run_d    = x_base;
      y_run_d    = y_base;
      line_vis_d = (hs_edge ? 1'b0 : line_vis_q) | vgaBlankN;
      if (vgaBlankN) begin
        x_ord_d = x_base;
        y_ord_d = y_base;
        x_run_d = x_base + 10'd1;
      end
    end
  end

  // Lock state machine: next-state decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH: if (vs_edge) state_d = ALIGN;
      ALIGN: begin
        if (hs_edge && h_bad)
          state_d = SEARCH;
        else if (vs_edge)
          state_d = v_bad ? SEARCH : LOCKED;
      end
      LOCKED: if ((vs_edge && v_bad) || h_lost) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
  end

  // Lock state machine: pulses and error accounting, only while locked.
  always_comb begin
    pix_valid_d  = 1'b0;
    line_err_d   = 1'b0;
    frame_done_d = 1'b0;
    err_cnt_d    = err_cnt_q;
    if (state_q == LOCKED) begin
      line_err_d   = (hs_edge && h_bad) || (vs_edge && v_bad) || h_lost;
      frame_done_d = vs_edge && (state_d == LOCKED);
      pix_valid_d  = pixEn && vgaBlankN && (state_d == LOCKED);
      if (line_err_d && err_cnt_q != 8'hFF)
        err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // State register.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state_q <= SEARCH;
    else         state_q <= state_d;
  end

  // Datapath and output registers; held values come from the _d logic when pixEn=0.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      hs_prev_q    <= ~HS_ACTIVE;
      vs_prev_q    <= ~VS_ACTIVE;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      h_total_q    <= '0;
      v_total_q    <= '0;
      x_run_q      <= '0;
      y_run_q      <= '0;
      line_vis_q   <= 1'b0;
      x_ord_q      <= '0;
      y_ord_q      <= '0;
      err_cnt_q    <= '0;
      pix_valid_q  <= 1'b0;
      line_err_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      hs_prev_q    <= hs_prev_d;
      vs_prev_q    <= vs_prev_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      h_total_q    <= h_total_d;
      v_total_q    <= v_total_d;
      x_run_q      <= x_run_d;
      y_run_q      <= y_run_d;
      line_vis_q   <= line_vis_d;
      x_ord_q      <= x_ord_d;
      y_ord_q      <= y_ord_d;
      err_cnt_q    <= err_cnt_d;
      pix_valid_q  <= pix_valid_d;
      line_err_q   <= line_err_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign xOrd       = x_ord_q;
  assign yOrd       = y_ord_q;
  assign pixValid   = pix_valid_q;
  assign locked     = (state_q == LOCKED);
  assign lineErr    = line_err_q;
  assign frameDone  = frame_done_q;
  assign hTotalMeas = h_total_q;
  assign vTotalMeas = v_total_q;
  assign errCount   = err_cnt_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver using a reduced 20x12 timing:
// 12 visible pixels + 2 front porch + 3 sync + 3 back porch per line,
// 6 visible lines + 1 front porch + 2 sync + 3 back porch per frame.
module tb_vga_sync_receiver;

  localparam int H_T   = 20;
  localparam int V_T   = 12;
  localparam int H_VIS = 12;
  localparam int V_VIS = 6;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       pixEn = 1'b0;
  logic       vgaHs = 1'b1;
  logic       vgaVs = 1'b1;
  logic       vgaBlankN = 1'b0;
  logic [9:0] xOrd, yOrd, hTotalMeas, vTotalMeas;
  logic       pixValid, locked, lineErr, frameDone;
  logic [7:0] errCount;

  int n_cmp = 0;
  int n_fail = 0;

  // stream generator state
  int gh = 0, gv = 0;
  int hlen = H_T, hlen_def = H_T;
  int vlen = V_T, vlen_def = V_T;
  bit hs_en = 1'b1, vs_en = 1'b1;

  // pulse accumulators
  int pv_cnt = 0, le_cnt = 0, fd_cnt = 0;
  int last_x = -1, last_y = -1;
  int line_idx;

  vga_sync_receiver #(.H_TOTAL(H_T), .V_TOTAL(V_T), .HS_ACTIVE(1'b0), .VS_ACTIVE(1'b0)) dut (
    .CLOCK_50  (clk),
    .resetn    (resetn),
    .pixEn     (pixEn),
    .vgaHs     (vgaHs),
    .vgaVs     (vgaVs),
    .vgaBlankN (vgaBlankN),
    .xOrd      (xOrd),
    .yOrd      (yOrd),
    .pixValid  (pixValid),
    .locked    (locked),
    .lineErr   (lineErr),
    .frameDone (frameDone),
    .hTotalMeas(hTotalMeas),
    .vTotalMeas(vTotalMeas),
    .errCount  (errCount)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One pixel strobe (pixEn every second cycle); outputs sampled at the following negedge.
  task automatic strobe();
    @(negedge clk);
    vgaBlankN = (gh < H_VIS) && (gv < V_VIS);
    vgaHs     = (hs_en && gh >= 14 && gh < 17) ? 1'b0 : 1'b1;
    vgaVs     = (vs_en && gv >= 7 && gv < 9) ? 1'b0 : 1'b1;
    pixEn     = 1'b1;
    @(negedge clk);
    pixEn = 1'b0;
    if (pixValid) begin
      pv_cnt++;
      last_x = int'(xOrd);
      last_y = int'(yOrd);
    end
    if (lineErr) le_cnt++;
    if (frameDone) fd_cnt++;
    gh++;
    if (gh >= hlen) begin
      gh = 0;
      hlen = hlen_def;
      gv++;
      if (gv >= vlen) begin
        gv = 0;
        vlen = vlen_def;
      end
    end
  endtask

  // Strobe until the sample at generator position (tv, th) has been taken.
  task automatic run_to(input int tv, input int th);
    int sv, sh, n;
    n = 0;
    do begin
      sv = gv;
      sh = gh;
      strobe();
      n++;
    end while (!(sv == tv && sh == th) && n < 4000);
    n_cmp++;
    assert (sv == tv && sh == th) else begin
      n_fail++;
      $error("FAIL run_to_timeout: observed %0d,%0d expected %0d,%0d", sv, sh, tv, th);
    end
  endtask

  task automatic clr();
    pv_cnt = 0; le_cnt = 0; fd_cnt = 0; last_x = -1; last_y = -1;
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_errcnt", 32'(errCount), 0);
    chk("rst_htot", 32'(hTotalMeas), 0);
    chk("rst_xy", {xOrd, yOrd}, 0);
    resetn = 1'b1;

    // 1: acquire lock on the second vsync edge, then one nominal frame
    run_to(7, 0);
    chk("t1_lock_after_vs1", 32'(locked), 0);
    run_to(7, 0);
    chk("t1_lock_after_vs2", 32'(locked), 1);
    chk("t1_htot", 32'(hTotalMeas), H_T);
    chk("t1_vtot", 32'(vTotalMeas), V_T);
    clr();
    run_to(7, 0);
    chk("t1_pix_count", pv_cnt, H_VIS * V_VIS);
    chk("t1_last_x", last_x, H_VIS - 1);
    chk("t1_last_y", last_y, V_VIS - 1);
    chk("t1_frame_done", fd_cnt, 1);
    chk("t1_line_err", le_cnt, 0);

    // 2: one stretched line while locked
    run_to(2, 0);
    hlen = H_T + 1;
    clr();
    run_to(3, 14);
    chk("t2_lineerr_pulse", 32'(lineErr), 1);
    chk("t2_lineerr_cnt", le_cnt, 1);
    chk("t2_errcnt", 32'(errCount), 1);
    chk("t2_htot", 32'(hTotalMeas), H_T + 1);
    chk("t2_locked", 32'(locked), 1);
    run_to(4, 14);
    chk("t2_htot_next", 32'(hTotalMeas), H_T);
    chk("t2_errcnt_next", 32'(errCount), 1);

    // 3: one short frame while locked
    clr();
    run_to(7, 0);
    chk("t3_good_frame_done", 32'(frameDone), 1);
    vlen = V_T - 1;
    clr();
    run_to(7, 0);
    chk("t3_lineerr", 32'(lineErr), 1);
    chk("t3_framedone_exit", 32'(frameDone), 0);
    chk("t3_locked", 32'(locked), 0);
    chk("t3_errcnt", 32'(errCount), 2);
    chk("t3_vtot", 32'(vTotalMeas), V_T - 1);
    run_to(7, 0);
    chk("t3_relock_vs1", 32'(locked), 0);
    run_to(7, 0);
    chk("t3_relock_vs2", 32'(locked), 1);
    chk("t3_vtot_good", 32'(vTotalMeas), V_T);

    // 4: hsync lost while locked (vsync also held off so only the line timeout acts)
    run_to(8, 14);
    hs_en = 1'b0;
    vs_en = 1'b0;
    clr();
    repeat (1022) strobe();
    chk("t4_locked_1022", 32'(locked), 1);
    chk("t4_no_err_yet", le_cnt, 0);
    strobe();
    chk("t4_locked_1023", 32'(locked), 0);
    chk("t4_lineerr", 32'(lineErr), 1);
    chk("t4_errcnt", 32'(errCount), 3);
    clr();
    repeat (60) strobe();
    chk("t4_no_pixvalid", pv_cnt, 0);
    chk("t4_no_more_err", le_cnt, 0);

    // 5: relock, then reset mid-frame
    run_to(0, 0);
    hs_en = 1'b1;
    vs_en = 1'b1;
    run_to(7, 0);
    run_to(7, 0);
    chk("t5_locked_pre", 32'(locked), 1);
    run_to(3, 5);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("t5_rst_locked", 32'(locked), 0);
    chk("t5_rst_errcnt", 32'(errCount), 0);
    chk("t5_rst_htot", 32'(hTotalMeas), 0);
    chk("t5_rst_vtot", 32'(vTotalMeas), 0);
    chk("t5_rst_xy", {xOrd, yOrd}, 0);
    chk("t5_rst_pulses", {pixValid, lineErr, frameDone}, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    strobe();
    chk("t5_first_xy", {xOrd, yOrd}, 0);
    run_to(7, 0);
    chk("t5_relock_vs1", 32'(locked), 0);
    run_to(7, 0);
    chk("t5_relock_vs2", 32'(locked), 1);
    run_to(0, 0);
    chk("t5_first_pixvalid", 32'(pixValid), 1);
    chk("t5_first_locked_xy", {xOrd, yOrd}, 0);

    // 6: 300 short lines while locked; error counter saturates
    hlen = H_T - 1;
    hlen_def = H_T - 1;
    run_to(0, 14);
    chk("t6_boundary_line_ok", 32'(lineErr), 0);
    clr();
    line_idx = 0;
    for (int i = 0; i < 300; i++) begin
      line_idx = (line_idx + 1) % V_T;
      run_to(line_idx, 14);
      if (i == 253) chk("t6_errcnt_254", 32'(errCount), 254);
    end
    chk("t6_lineerr_cnt", le_cnt, 300);
    chk("t6_errcnt_sat", 32'(errCount), 255);
    chk("t6_locked", 32'(locked), 1);
    chk("t6_htot", 32'(hTotalMeas), H_T - 1);
    chk("t6_frame_done", fd_cnt, 25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
